i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

- Consumes the 24-bit signed audio samples produced by the synthesizer's tone generators.
- Serializes them to the board audio codec DAC as an I2S stream. The block generates the codec bit clock and the left/right clock.
- Every mono sample is sent on both channels.
- One sample is buffered with a valid/ready handshake, so the upstream stage may run at any rate up to one sample per frame.

## Interface
- BCLK_HALF, 8: clk cycles per half bit-clock period. Must be ≥2. Frame period is 128·BCLK_HALF clk (1024 at default).
- clk  in  1  system clock; all logic is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_in  in  24  two's-complement sample, MSB first on the wire.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  holding register empty; transfer occurs when valid & ready.
- mute  in  1  when high, the latched frame sample is forced to zero.
- aud_bclk  out  1  I2S bit clock.
- aud_daclrck  out  1  I2S word select: 0 = left slot, 1 = right slot.
- aud_dacdat  out  1  I2S serial data.
- frame_start  out  1  one-clk pulse when a new frame sample is latched.
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty.

## Operation
- **Divider:** counter 0..BCLK_HALF-1. At terminal count it wraps and aud_bclk toggles. A high→low toggle is a "falling strobe".
- **Bit counter:** bit_cnt, 6 bits, counts 0..63 and advances on each falling strobe; 63 wraps to 0.
  - aud_daclrck = bit_cnt[5], registered.
  - Each slot is 32 bit-clocks.
- **Data (I2S one-bit delay):** on each falling strobe, with k = new bit_cnt[4:0]:
  - k in 1..24: aud_dacdat = frame_sample[24-k].
  - otherwise: aud_dacdat = 0.
  - The same frame_sample is sent in both slots.
- **Holding register:** one entry.
  - On valid & ready it stores sample_in and sets full.
  - sample_ready = !full, registered.
- **Frame latch:** on the falling strobe where bit_cnt wraps 63→0, pulse frame_start.
  - full: frame_sample ← (mute ? 0 : holding) and full clears. sample_ready is high the next clk.
  - empty: frame_sample ← 0 and underrun pulses.
- **Simultaneous accept and latch with the register empty:** the latch sees it empty (zero frame, underrun). The incoming sample is stored and used next frame.
- **mute:** sampled only at the latch; it does not block consumption.

## Timing
- **Reset values:** aud_bclk 0, aud_daclrck 0, aud_dacdat 0, frame_start 0, underrun 0, sample_ready 1.
  - Internal: divider 0, bit_cnt 63, frame_sample 0, full 0.
- **First edges after reset release:** the first aud_bclk rise is at clk BCLK_HALF. The first falling strobe at clk 2·BCLK_HALF wraps bit_cnt 63→0 and performs the first frame latch.
- **Output alignment:** aud_dacdat and aud_daclrck change only on falling strobes, aligned with the aud_bclk fall. They are stable across each rising edge.
- **Sample latency:** a sample accepted before a latch appears with its MSB on aud_dacdat 1 bit-clock after aud_daclrck falls.
- **Reset mid-operation:** outputs go to reset values immediately. The pending holding sample is discarded.

## Structure
- Shared package synth_audio_pkg holds:
  - SAMPLE_W=24, SLOT_W=32, FRAME_BCLKS=64.
  - typedef sample_t (logic signed [SAMPLE_W-1:0]).
  - The tone generator output should migrate to sample_t.
- Sub-module i2s_clock_gen provides the divider, aud_bclk, falling strobe, bit_cnt and aud_daclrck. The top level holds the handshake, latch and shifter.

## Test plan
- **Reset release:** aud_bclk first rises at clk 8 and sample_ready=1. The first wrap pulses frame_start and underrun together at clk 16 with aud_dacdat all-zero; frame_start then pulses every 1024 clk.
- **Data order:** load 24'h800001 before a frame. Each slot shows 0, then 1, 22×0, 1, then 7×0. aud_daclrck=0 for the left slot and 1 for the right slot.
- **Underrun:** no sample offered → underrun and frame_start pulse in the same clk, and the next frame is 64 zero bits.
- **Mute:** mute=1 with 24'h7FFFFF loaded → zero frame. sample_ready rises the clk after frame_start.
- **Backpressure:** hold sample_valid with 24'h000ABC then 24'h123456. The second is accepted exactly 1 clk after frame_start and appears in the following frame.
- **Reset mid-slot:** reset at bit_cnt=10 → all outputs 0 within the same clk. After release the sequence restarts as in the reset-release scenario.

Source files
------------

// File: rtl/synth_audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synth_audio_pkg                                                      |
// | Shared audio types and frame geometry for the synthesizer datapath.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package synth_audio_pkg;

   localparam int SAMPLE_W    = 24;
   localparam int SLOT_W      = 32;
   localparam int FRAME_BCLKS = 64;
   localparam int CNT_W       = $clog2(FRAME_BCLKS);
   localparam int SLOT_IDX_W  = $clog2(SLOT_W);

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clock_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_clock_gen                                                        |
// | Bit-clock divider, falling strobe, frame bit counter and word select.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_clock_gen
   import synth_audio_pkg::*;
#(
   parameter int BCLK_HALF = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  bclk,
   output logic                  fall_strobe,
   output logic [CNT_W-1:0]      bit_cnt,
   output logic [SLOT_IDX_W-1:0] slot_bit_next,
   output logic                  daclrck
);

   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

   logic [DIV_W-1:0] r_div;
   logic             r_bclk;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_lrck;
   logic             w_div_tc;
   logic             w_fall;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_div_tc   = (r_div == DIV_W'(BCLK_HALF - 1));
   assign w_fall     = w_div_tc & r_bclk;
   assign w_cnt_next = r_bit_cnt + 1'b1;

   // Counter resets to 63 so the very first falling strobe wraps and latches a frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div     <= '0;
         r_bclk    <= 1'b0;
         r_bit_cnt <= '1;
         r_lrck    <= 1'b0;
      end else begin
         if (w_div_tc) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
         end else begin
            r_div  <= r_div + 1'b1;
         end
         if (w_fall) begin
            r_bit_cnt <= w_cnt_next;
            r_lrck    <= w_cnt_next[CNT_W-1];
         end
      end
   end

   assign bclk          = r_bclk;
   assign fall_strobe   = w_fall;
   assign bit_cnt       = r_bit_cnt;
   assign slot_bit_next = w_cnt_next[SLOT_IDX_W-1:0];
   assign daclrck       = r_lrck;

endmodule
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_dac_tx                                                           |
// | One-deep sample buffer and I2S serializer, mono copied to both slots.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_dac_tx
   import synth_audio_pkg::*;
#(
   parameter int BCLK_HALF = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic                mute,
   output logic                aud_bclk,
   output logic                aud_daclrck,
   output logic                aud_dacdat,
   output logic                frame_start,
   output logic                underrun
);

   logic                  w_fall;
   logic [CNT_W-1:0]      w_bit_cnt;
   logic [SLOT_IDX_W-1:0] w_k;
   logic [SLOT_IDX_W-1:0] w_idx;
   logic                  w_bit_on;
   logic                  w_latch;
   logic                  w_accept;
   logic                  w_full_next;
   logic                  w_ready_next;

   sample_t r_hold;
   sample_t r_frame_sample;
   logic    r_full;
   logic    r_ready;
   logic    r_dacdat;
   logic    r_frame_start;
   logic    r_underrun;

   i2s_clock_gen #(
      .BCLK_HALF     (BCLK_HALF)
   ) u_clock_gen (
      .clk           (clk),
      .reset         (reset),
      .bclk          (aud_bclk),
      .fall_strobe   (w_fall),
      .bit_cnt       (w_bit_cnt),
      .slot_bit_next (w_k),
      .daclrck       (aud_daclrck)
   );

   assign w_latch  = w_fall & (&w_bit_cnt);
   assign w_accept = sample_valid & r_ready;
   assign w_bit_on = (w_k != '0) && (w_k <= SLOT_IDX_W'(SAMPLE_W));
   assign w_idx    = SLOT_IDX_W'(SAMPLE_W) - w_k;

   // The latch consumes the old contents first; a same-cycle accept refills the register.
   always_comb begin
      w_full_next = r_full;
      if (w_latch) begin
         w_full_next = 1'b0;
      end
      if (w_accept) begin
         w_full_next = 1'b1;
      end
   end

   // Ready reopens one clk after the latch that drained the register.
   assign w_ready_next = ~w_full_next & ~(w_latch & r_full);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold         <= '0;
         r_frame_sample <= '0;
         r_full         <= 1'b0;
         r_ready        <= 1'b1;
         r_dacdat       <= 1'b0;
         r_frame_start  <= 1'b0;
         r_underrun     <= 1'b0;
      end else begin
         r_full        <= w_full_next;
         r_ready       <= w_ready_next;
         r_frame_start <= w_latch;
         r_underrun    <= w_latch & ~r_full;
         if (w_accept) begin
            r_hold <= sample_in;
         end
         if (w_latch) begin
            r_frame_sample <= (r_full & ~mute) ? r_hold : '0;
         end
         if (w_fall) begin
            r_dacdat <= w_bit_on ? r_frame_sample[w_idx] : 1'b0;
         end
      end
   end

   assign sample_ready = r_ready;
   assign aud_dacdat   = r_dacdat;
   assign frame_start  = r_frame_start;
   assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2s_dac_tx                                                        |
// | Scoreboarded bench: expected frames queued, serial bits compared.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2s_dac_tx;

   localparam int BCLK_HALF  = 8;
   localparam int FRAME_CLKS = 128 * BCLK_HALF;

   typedef struct {
      logic [23:0] value;
      logic        urun;
   } frame_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [23:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        mute = 1'b0;
   logic        sample_ready;
   logic        aud_bclk;
   logic        aud_daclrck;
   logic        aud_dacdat;
   logic        frame_start;
   logic        underrun;

   int          checks = 0;
   int          failures = 0;
   int          frames_checked = 0;
   frame_exp_t  sb[$];

   always #5 clk = ~clk;

   i2s_dac_tx #(
      .BCLK_HALF    (BCLK_HALF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .mute         (mute),
      .aud_bclk     (aud_bclk),
      .aud_daclrck  (aud_daclrck),
      .aud_dacdat   (aud_dacdat),
      .frame_start  (frame_start),
      .underrun     (underrun)
   );

   // Pops one expected frame per frame_start and checks the 64 bits seen on bclk rises.
   task automatic monitor();
      frame_exp_t exp_f;
      logic       active = 1'b0;
      logic       prev_bclk = 1'b0;
      int         pos = 0;
      int         k;
      logic       exp_dat;
      logic       exp_lr;
      forever begin
         @(negedge clk);
         if (!reset) begin
            active    = 1'b0;
            prev_bclk = 1'b0;
         end else begin
            if (frame_start) begin
               if (active) begin
                  checks++;
                  if (pos != 64) begin
                     failures++;
                     $display("FAIL frame_length bits=%0d expected=64", pos);
                  end
               end
               active = 1'b0;
               if (sb.size() > 0) begin
                  exp_f  = sb.pop_front();
                  active = 1'b1;
                  pos    = 0;
                  checks++;
                  if (underrun !== exp_f.urun) begin
                     failures++;
                     $display("FAIL frame_underrun got=%b expected=%b", underrun, exp_f.urun);
                  end
               end
            end
            if (aud_bclk && !prev_bclk && active && pos < 64) begin
               k       = pos % 32;
               exp_dat = (k >= 1 && k <= 24) ? exp_f.value[24 - k] : 1'b0;
               exp_lr  = (pos >= 32);
               checks++;
               if (aud_dacdat !== exp_dat || aud_daclrck !== exp_lr) begin
                  failures++;
                  $display("FAIL frame_bit sample=%h pos=%0d dat=%b lrck=%b expected dat=%b lrck=%b",
                           exp_f.value, pos, aud_dacdat, aud_daclrck, exp_dat, exp_lr);
               end
               pos++;
               if (pos == 64) frames_checked++;
            end
            prev_bclk = aud_bclk;
         end
      end
   endtask

   task automatic wait_fs();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 2 * FRAME_CLKS);
      checks++;
      if (frame_start !== 1'b1) begin
         failures++;
         $display("FAIL frame_start_timeout waited=%0d expected<=%0d", n, FRAME_CLKS);
      end
   endtask

   task automatic send_sample(input logic [23:0] v);
      int n = 0;
      sample_in    = v;
      sample_valid = 1'b1;
      while (!sample_ready && n < 3 * FRAME_CLKS) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      checks++;
      if (sample_ready !== 1'b0) begin
         failures++;
         $display("FAIL accept sample=%h ready_after=%b expected=0", v, sample_ready);
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, sample_ready} !== 6'b000001) begin
         failures++;
         $display("FAIL reset_values got=%b expected=000001",
                  {aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, sample_ready});
      end
      sb.push_back('{value: 24'h0, urun: 1'b1});
      reset = 1'b1;
      for (int e = 1; e <= 17; e++) begin
         @(negedge clk);
         if (e == 7 || e == 8) begin
            checks++;
            if (aud_bclk !== (e == 8)) begin
               failures++;
               $display("FAIL bclk_first_rise clk=%0d got=%b expected=%b", e, aud_bclk, e == 8);
            end
         end
         if (e == 8) begin
            checks++;
            if (sample_ready !== 1'b1) begin
               failures++;
               $display("FAIL ready_after_reset got=%b expected=1", sample_ready);
            end
         end
         if (e == 15 || e == 16 || e == 17) begin
            checks++;
            if (frame_start !== (e == 16) || underrun !== (e == 16)) begin
               failures++;
               $display("FAIL first_frame clk=%0d frame_start=%b underrun=%b expected=%b",
                        e, frame_start, underrun, e == 16);
            end
         end
      end
      n = 1;
      while (!frame_start && n < 2 * FRAME_CLKS) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != FRAME_CLKS || frame_start !== 1'b1) begin
         failures++;
         $display("FAIL frame_period got=%0d expected=%0d", n, FRAME_CLKS);
      end
   endtask

   task automatic test_data_order();
      @(negedge clk);
      sb.push_back('{value: 24'h800001, urun: 1'b0});
      send_sample(24'h800001);
      wait_fs();
      checks++;
      if (underrun !== 1'b0 || aud_daclrck !== 1'b0) begin
         failures++;
         $display("FAIL data_frame_start underrun=%b lrck=%b expected 0 0", underrun, aud_daclrck);
      end
      wait_fs();
   endtask

   task automatic test_underrun();
      @(negedge clk);
      sb.push_back('{value: 24'h0, urun: 1'b1});
      wait_fs();
      checks++;
      if (underrun !== 1'b1) begin
         failures++;
         $display("FAIL underrun_pulse got=%b expected=1", underrun);
      end
      @(negedge clk);
      checks++;
      if (underrun !== 1'b0) begin
         failures++;
         $display("FAIL underrun_width got=%b expected=0", underrun);
      end
      wait_fs();
   endtask

   task automatic test_mute();
      @(negedge clk);
      mute = 1'b1;
      sb.push_back('{value: 24'h0, urun: 1'b0});
      send_sample(24'h7FFFFF);
      wait_fs();
      checks++;
      if (sample_ready !== 1'b0) begin
         failures++;
         $display("FAIL mute_ready_at_latch got=%b expected=0", sample_ready);
      end
      @(negedge clk);
      mute = 1'b0;
      checks++;
      if (sample_ready !== 1'b1) begin
         failures++;
         $display("FAIL mute_ready_after_latch got=%b expected=1", sample_ready);
      end
      wait_fs();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      sb.push_back('{value: 24'h000ABC, urun: 1'b0});
      sb.push_back('{value: 24'h123456, urun: 1'b0});
      send_sample(24'h000ABC);
      sample_in    = 24'h123456;
      sample_valid = 1'b1;
      wait_fs();
      checks++;
      if (sample_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_ready_at_latch got=%b expected=0", sample_ready);
      end
      @(negedge clk);
      checks++;
      if (sample_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready_one_after got=%b expected=1", sample_ready);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      checks++;
      if (sample_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second_accept ready=%b expected=0", sample_ready);
      end
      wait_fs();
      checks++;
      if (underrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second_frame underrun=%b expected=0", underrun);
      end
      wait_fs();
   endtask

   task automatic test_reset_mid();
      int   falls = 0;
      int   n = 0;
      logic prev;
      @(negedge clk);
      sb.push_back('{value: 24'hFFFFFF, urun: 1'b0});
      send_sample(24'hFFFFFF);
      wait_fs();
      sample_in    = 24'h5A5A5A;
      sample_valid = 1'b1;
      prev = aud_bclk;
      while (falls < 10 && n < 2 * FRAME_CLKS) begin
         @(negedge clk);
         n++;
         if (prev && !aud_bclk) falls++;
         prev = aud_bclk;
         if (falls == 1) sample_valid = 1'b0;
      end
      checks++;
      if (aud_dacdat !== 1'b1 || aud_daclrck !== 1'b0 || sample_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_slot_state dat=%b lrck=%b ready=%b expected 1 0 0",
                  aud_dacdat, aud_daclrck, sample_ready);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, sample_ready} !== 6'b000001) begin
         failures++;
         $display("FAIL mid_reset_values got=%b expected=000001",
                  {aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun, sample_ready});
      end
      repeat (3) @(negedge clk);
      sb.push_back('{value: 24'h0, urun: 1'b1});
      reset = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         @(negedge clk);
         if (e == 7 || e == 8) begin
            checks++;
            if (aud_bclk !== (e == 8)) begin
               failures++;
               $display("FAIL restart_bclk clk=%0d got=%b expected=%b", e, aud_bclk, e == 8);
            end
         end
         if (e == 15 || e == 16) begin
            checks++;
            if (frame_start !== (e == 16) || underrun !== (e == 16)) begin
               failures++;
               $display("FAIL restart_frame clk=%0d frame_start=%b underrun=%b expected=%b",
                        e, frame_start, underrun, e == 16);
            end
         end
      end
      wait_fs();
      checks++;
      if (underrun !== 1'b1) begin
         failures++;
         $display("FAIL pending_discarded underrun=%b expected=1", underrun);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_data_order();
      test_underrun();
      test_mute();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sb.size() != 0 || frames_checked < 7) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d frames=%0d expected 0 and >=7",
                  sb.size(), frames_checked);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
